// File: rtl/pc_bist_pkg.sv
// Shared types and helpers for the parallel-counter self-test driver.
package pc_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int PC_N    = 7;
    localparam int NUM_VEC = 1 << PC_N;

    // Reference population count; callers truncate to their count width.
    function automatic logic [7:0] popcount(input logic [31:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pc_bist_pipe.sv
// LAT-deep delay line carrying {valid, vector, expected} alongside the counter pipeline.
// Synchronous active-low clear; a plain wire when LAT=0.
module pc_bist_pipe #(
    parameter int N   = 7,
    parameter int W   = 3,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         in_vld,
    input  logic [N-1:0] in_vec,
    input  logic [W-1:0] in_exp,
    output logic         out_vld,
    output logic [N-1:0] out_vec,
    output logic [W-1:0] out_exp
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_pipe;
            assign unused_pipe = ^{clk, clr_n};
            assign out_vld = in_vld;
            assign out_vec = in_vec;
            assign out_exp = in_exp;
        end else begin : g_regs
            logic         vld_q [LAT];
            logic [N-1:0] vec_q [LAT];
            logic [W-1:0] exp_q [LAT];

            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        vld_q[i] <= 1'b0;
                        vec_q[i] <= '0;
                        exp_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= in_vld;
                    vec_q[0] <= in_vec;
                    exp_q[0] <= in_exp;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        vec_q[i] <= vec_q[i-1];
                        exp_q[i] <= exp_q[i-1];
                    end
                end
            end

            assign out_vld = vld_q[LAT-1];
            assign out_vec = vec_q[LAT-1];
            assign out_exp = exp_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/pc_sn_bist.sv
// Exhaustive self-test for a sorting-network parallel counter: walks all 2^N inputs,
// checks each returned count against a popcount reference, reports pass/err/first fail.
module pc_sn_bist
    import pc_bist_pkg::*;
#(
    parameter int N    = 7,
    parameter int W    = 3,
    parameter int LAT  = 0,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N-1:0]    test_vec,
    input  logic [W-1:0]    dut_cnt,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [N-1:0]    first_fail_vec,
    output logic [W-1:0]    first_fail_exp
);

    localparam int DCW = (LAT > 1) ? $clog2(LAT + 1) : 1;
    localparam logic [N-1:0] LAST_VEC = '1;

    state_e          state_q, state_d;
    logic [N-1:0]    vec_q, vec_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [N-1:0]    ffv_q, ffv_d;
    logic [W-1:0]    ffe_q, ffe_d;

    logic         p_vld;
    logic [N-1:0] p_vec;
    logic [W-1:0] p_exp;
    logic [W-1:0] exp_now;

    assign exp_now = W'(popcount(32'(vec_q)));

    pc_bist_pipe #(.N(N), .W(W), .LAT(LAT)) u_pipe (
        .clk     (clk),
        .clr_n   (rst_n),
        .in_vld  (state_q == ST_DRIVE),
        .in_vec  (vec_q),
        .in_exp  (exp_now),
        .out_vld (p_vld),
        .out_vec (p_vec),
        .out_exp (p_exp)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffe_d   = ffe_q;

        if (p_vld && (dut_cnt != p_exp)) begin
            if (err_q == '0) begin
                ffv_d = p_vec;
                ffe_d = p_exp;
            end
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    ffv_d   = '0;
                    ffe_d   = '0;
                end
            end
            ST_DRIVE: begin
                // The last vector is held so a pipelined counter keeps seeing it while draining.
                if (vec_q == LAST_VEC) begin
                    state_d = (LAT > 0) ? ST_DRAIN : ST_DONE;
                    drain_d = '0;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DCW'(LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffe_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffe_q   <= ffe_d;
        end
    end

    assign test_vec       = vec_q;
    assign busy           = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign pass           = (state_q == ST_DONE) && (err_q == '0);
    assign err_cnt        = err_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_exp = ffe_q;

endmodule

// File: tb/tb_pc_sn_bist.sv
// Directed bench: three BIST instances (LAT=0, LAT=2, ERRW=4) each driving a behavioural counter model.
module tb_pc_sn_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LAT=0, ERRW=8 instance
    logic       start0;
    logic [6:0] tv0, ffv0;
    logic [2:0] cnt0, ffe0;
    logic       busy0, done0, pass0;
    logic [7:0] err0;
    int         mode0;

    // LAT=2, ERRW=8 instance
    logic       start2;
    logic [6:0] tv2, ffv2;
    logic [2:0] cnt2, ffe2, d1, d2, d3;
    logic       busy2, done2, pass2;
    logic [7:0] err2;
    int         mode2;

    // LAT=0, ERRW=4 instance
    logic       start4;
    logic [6:0] tv4, ffv4;
    logic [2:0] cnt4, ffe4;
    logic       busy4, done4, pass4;
    logic [3:0] err4;

    pc_sn_bist #(.N(7), .W(3), .LAT(0), .ERRW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .test_vec(tv0), .dut_cnt(cnt0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_fail_vec(ffv0), .first_fail_exp(ffe0)
    );

    pc_sn_bist #(.N(7), .W(3), .LAT(2), .ERRW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .test_vec(tv2), .dut_cnt(cnt2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_fail_vec(ffv2), .first_fail_exp(ffe2)
    );

    pc_sn_bist #(.N(7), .W(3), .LAT(0), .ERRW(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .test_vec(tv4), .dut_cnt(cnt4),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
        .first_fail_vec(ffv4), .first_fail_exp(ffe4)
    );

    // Counter models
    always_comb begin
        cnt0 = 3'($countones(tv0));
        if (mode0 == 1) cnt0 = 3'd0;
        else if (mode0 == 2 && tv0 == 7'h7F) cnt0 = 3'd6;
    end

    always_ff @(posedge clk) begin
        d1 <= 3'($countones(tv2));
        d2 <= d1;
        d3 <= d2;
    end
    assign cnt2 = (mode2 == 1) ? d3 : d2;
    assign cnt4 = 3'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start0 = v;
            2:       start2 = v;
            default: start4 = v;
        endcase
    endtask

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            2:       return busy2;
            default: return busy4;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done0;
            2:       return done2;
            default: return done4;
        endcase
    endfunction

    function automatic logic [7:0] get_err(input int sel);
        case (sel)
            0:       return err0;
            2:       return err2;
            default: return {4'd0, err4};
        endcase
    endfunction

    // Pulse start, count busy cycles, optionally re-pulse start mid-DRIVE.
    task automatic run_sel(input int sel, input bit repulse, output int bc);
        int guard;
        bc = 0;
        guard = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        check_eq("start_clears_done", 32'(get_done(sel)), 0);
        check_eq("start_clears_err", 32'(get_err(sel)), 0);
        while (get_busy(sel) && guard < 400) begin
            bc++;
            if (repulse && bc == 40) set_start(sel, 1'b1);
            if (repulse && bc == 41) set_start(sel, 1'b0);
            @(negedge clk);
            guard++;
        end
        check_eq("run_timeout", 32'(guard >= 400), 0);
        check_eq("done_after_run", 32'(get_done(sel)), 1);
    endtask

    initial begin
        int bc;
        int guard;
        rst_n = 1'b0;
        start0 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        mode0 = 0; mode2 = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_tv", 32'(tv0), 0);
        check_eq("rst_busy", 32'(busy0), 0);
        check_eq("rst_done", 32'(done0), 0);
        check_eq("rst_pass", 32'(pass0), 0);
        check_eq("rst_err", 32'(err0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean LAT=0 run
        run_sel(0, 1'b0, bc);
        check_eq("l0_busy_cycles", 32'(bc), 128);
        check_eq("l0_pass", 32'(pass0), 1);
        check_eq("l0_err", 32'(err0), 0);
        check_eq("l0_ffv", 32'(ffv0), 0);
        check_eq("l0_ffe", 32'(ffe0), 0);
        check_eq("l0_tv_hold", 32'(tv0), 32'h7F);

        // Stuck-at-0 counter
        mode0 = 1;
        run_sel(0, 1'b0, bc);
        check_eq("stuck_err", 32'(err0), 127);
        check_eq("stuck_ffv", 32'(ffv0), 1);
        check_eq("stuck_ffe", 32'(ffe0), 1);
        check_eq("stuck_pass", 32'(pass0), 0);

        // Single wrong answer at the last vector
        mode0 = 2;
        run_sel(0, 1'b0, bc);
        check_eq("last_err", 32'(err0), 1);
        check_eq("last_ffv", 32'(ffv0), 32'h7F);
        check_eq("last_ffe", 32'(ffe0), 7);
        check_eq("last_pass", 32'(pass0), 0);

        // Two-stage pipelined correct counter
        mode2 = 0;
        run_sel(2, 1'b0, bc);
        check_eq("l2_busy_cycles", 32'(bc), 130);
        check_eq("l2_pass", 32'(pass2), 1);
        check_eq("l2_err", 32'(err2), 0);

        // Counter one cycle slower than declared
        mode2 = 1;
        run_sel(2, 1'b0, bc);
        check_eq("l3_pass", 32'(pass2), 0);
        check_eq("l3_err_nonzero", 32'(err2 != 8'd0), 1);

        // Saturation with a 4-bit error counter
        run_sel(4, 1'b0, bc);
        check_eq("sat_err", 32'(err4), 15);
        check_eq("sat_pass", 32'(pass4), 0);

        // start during DRIVE is ignored
        mode0 = 0;
        run_sel(0, 1'b1, bc);
        check_eq("repulse_cycles", 32'(bc), 128);
        check_eq("repulse_pass", 32'(pass0), 1);

        // Reset mid-run at vector 50
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        guard = 0;
        while (tv0 != 7'd50 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_vec50", 32'(tv0), 50);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_tv", 32'(tv0), 0);
        check_eq("mid_rst_busy", 32'(busy0), 0);
        check_eq("mid_rst_done", 32'(done0), 0);
        check_eq("mid_rst_pass", 32'(pass0), 0);
        check_eq("mid_rst_err", 32'(err0), 0);
        check_eq("mid_rst_ffv", 32'(ffv0), 0);
        check_eq("mid_rst_ffe", 32'(ffe0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sel(0, 1'b0, bc);
        check_eq("post_rst_cycles", 32'(bc), 128);
        check_eq("post_rst_pass", 32'(pass0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sn_bist.md
Name: pc_sn_bist

Overview:
Sequential self-test driver and checker for the sorting-network parallel counters, such as the 7:3 counter.
- Acts as the stimulus end of the counter's interface: it drives the counter input vector and reads back the counter's count output.
- Walks all 2^N input patterns, compares each observed count against a reference popcount, and reports pass/fail, an error count and the first failing vector.
- Sits next to the counter in the FPGA top. `start` comes from a debounced button; `pass`/`done` go to LEDs.

Parameters:
N, 7, counter input width (number of bits counted)
W, 3, count width = clog2(N+1)
LAT, 0, counter pipeline latency in cycles (0 = combinational counter)
ERRW, 8, width of error counter

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  begin a test run; sampled only in IDLE or DONE
test_vec  output  N  stimulus to counter input; registered
dut_cnt  input  W  counter output under test
busy  output  1  high while a run is in progress
done  output  1  high from run completion until next accepted start
pass  output  1  valid when done=1; 1 iff err_cnt==0
err_cnt  output  ERRW  number of mismatches in the last run, saturating
first_fail_vec  output  N  stimulus of the first mismatch in the run; 0 if none
first_fail_exp  output  W  expected count for first_fail_vec; 0 if none

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; test_vec=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_exp=0. The expected-value pipeline is cleared. Reset mid-run aborts immediately with no partial results retained.
- States: IDLE, DRIVE, DRAIN, DONE.
- IDLE/DONE with start=1:
  - Next cycle: state=DRIVE, test_vec=0, busy=1, done=0, pass=0, err_cnt=0, first_fail_* cleared.
  - start in DRIVE/DRAIN is ignored.
- DRIVE:
  - test_vec increments by 1 each cycle.
  - After the cycle presenting 2^N-1, go to DRAIN if LAT>0, else DONE.
  - test_vec holds 2^N-1 after DRIVE ends.
  - DRIVE lasts exactly 2^N cycles.
- Compare timing:
  - The vector presented in cycle t is checked against dut_cnt sampled in cycle t+LAT.
  - Expected popcount(test_vec) plus a valid bit travel through a LAT-deep register pipeline. For LAT=0, the compare is in the same cycle.
  - A compare happens only when the pipeline valid bit is 1. Exactly 2^N compares occur per run.
- DRAIN: lasts LAT cycles, compares only, then go to DONE.
- DONE: busy=0, done=1, pass=(err_cnt==0). Outputs hold until reset or a new start.
- Mismatch:
  - err_cnt increments, saturating at 2^ERRW-1.
  - On the first mismatch of the run (err_cnt==0 before the update), capture the delayed vector and expected value into first_fail_*.
- Popcount arithmetic is unsigned W bits; the maximum value N always fits.
- busy is high for exactly 2^N+LAT cycles per run.

Decomposition:
- Package pc_bist_pkg holds:
  - the state enum (IDLE, DRIVE, DRAIN, DONE);
  - function popcount(N-bit) returning W bits;
  - localparam NUM_VEC=2^N.
- Sub-module pc_bist_pipe: a LAT-deep delay line carrying {valid, vector, expected}. It has a synchronous active-low clear and is a pass-through when LAT=0.
- FSM, counters and capture logic live in pc_sn_bist.

Test Plan:
- Correct 7:3 counter attached, LAT=0, pulse start -> busy high 128 cycles; then done=1, pass=1, err_cnt=0, first_fail_vec=0.
- Counter model stuck at 3'b000 -> err_cnt=127, first_fail_vec=7'h01, first_fail_exp=1, pass=0.
- Model returns 6 only for vector 7'h7F, LAT=0 -> err_cnt=1, first_fail_vec=7'h7F, first_fail_exp=7.
- LAT=2 with a 2-stage registered correct model -> busy 130 cycles, pass=1.
- Same LAT=2 setup, model output delayed by 3 cycles -> pass=0, err_cnt>0.
- ERRW=4 with stuck-at-0 model -> err_cnt saturates at 15, no wrap.
- rst_n=0 while test_vec=50 -> next cycle all outputs at reset values.
- After the reset, start -> full clean run, pass=1.
- start re-pulsed mid-DRIVE -> ignored, run length unchanged.
- start in DONE -> results cleared and a new run begins.
